pipe_stages: RTL and testbench

- Parametrised elastic pipeline: DEPTH registered stages of WIDTH-bit data, with a valid/ready handshake on both ends.
- Each stage is a 2-entry skid buffer, so the upstream ready is registered and there is no combinational ready path through the chain.
- Sustains one transfer per cycle; total buffering is 2*DEPTH entries.
- Replaces the fixed 8-bit single-register pipe. Adds backpressure, flush and an occupancy count.
- Sits between producer and consumer blocks that need timing isolation.

---
 rtl/pipe_stages.sv | 170 +++++++++++++++++
 tb/tb_pipe_stages.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stages.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_stages: elastic pipeline of DEPTH two-entry skid stages with flush/count.
// Rev 1.0
// ----------------------------------------------------------------------------

module pipe_stages_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             up_valid_i,
    output logic             up_ready_o,
    output logic [WIDTH-1:0] dn_data_o,
    output logic             dn_valid_o,
    input  logic             dn_ready_i
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             valid_q;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push       = up_valid_i & ready_q;
    assign pop        = valid_q & dn_ready_i;
    assign up_ready_o = ready_q;
    assign dn_valid_o = valid_q;
    assign dn_data_o  = main_q;

    // valid_q/ready_q are kept as registered decodes of state_q so that
    // downstream ready never reaches upstream ready combinationally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else if (flush) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_q  <= up_data_i;
                        state_q <= ST_ONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_q <= up_data_i;
                    end else if (push) begin
                        skid_q  <= up_data_i;
                        state_q <= ST_TWO;
                        ready_q <= 1'b0;
                    end else if (pop) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_q  <= skid_q;
                        state_q <= ST_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

module pipe_stages #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(2*DEPTH+1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] stg_data [DEPTH+1];
    logic [DEPTH:0]   stg_valid;
    logic [DEPTH:0]   stg_ready;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             in_acc;
    logic             out_acc;

    assign stg_data[0]      = in_data;
    assign stg_valid[0]     = in_valid;
    assign in_ready         = stg_ready[0];
    assign out_data         = stg_data[DEPTH];
    assign out_valid        = stg_valid[DEPTH];
    assign stg_ready[DEPTH] = out_ready;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            pipe_stages_skid #(
                .WIDTH (WIDTH)
            ) u_skid (
                .clock      (clock),
                .reset      (reset),
                .flush      (flush),
                .up_data_i  (stg_data[k]),
                .up_valid_i (stg_valid[k]),
                .up_ready_o (stg_ready[k]),
                .dn_data_o  (stg_data[k+1]),
                .dn_valid_o (stg_valid[k+1]),
                .dn_ready_i (stg_ready[k+1])
            );
        end
    endgenerate

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    // Occupancy cannot overflow: in_acc already requires a free slot.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_acc && !out_acc) begin
            count_d = count_q + CW'(1);
        end else if (!in_acc && out_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stages.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_stages: directed scoreboard bench for pipe_stages (WIDTH=8, DEPTH=3).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_stages;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(2*DEPTH+1);

    logic             clock     = 1'b0;
    logic             reset     = 1'b0;
    logic             flush     = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CW-1:0]    count;

    pipe_stages #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clock = ~clock;

    int               n_checks = 0;
    int               n_pass   = 0;
    int               n_acc    = 0;
    int               n_out    = 0;
    logic [WIDTH-1:0] exp_q[$];
    bit               stall_pending = 1'b0;
    logic [WIDTH-1:0] stall_data    = '0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge reset) stall_pending = 1'b0;

    // Monitor: inputs/outputs are stable at the falling edge, so any handshake
    // seen here completes at the following rising edge.
    always @(negedge clock) begin
        if (reset) begin
            if (stall_pending) begin
                check("stall_valid_held", int'(out_valid), 1);
                check("stall_data_held", int'(out_data), int'(stall_data));
            end
            stall_pending = out_valid && !out_ready && !flush;
            stall_data    = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("output_with_empty_scoreboard", exp_q.size(), 1);
                else check("out_data_order", int'(out_data), int'(exp_q.pop_front()));
                n_out++;
            end
            if (in_valid && in_ready && !flush) begin
                exp_q.push_back(in_data);
                n_acc++;
            end
            check("count_in_range", int'(count <= CW'(2*DEPTH)), 1);
        end
    end

    task automatic push(input logic [WIDTH-1:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("push_accepted", int'(ok), 1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            done = (exp_q.size() == 0) && !out_valid;
        end
        check("drain_scoreboard_empty", exp_q.size(), 0);
        check("drain_count_zero", int'(count), 0);
    endtask

    initial begin
        int  acc0;
        int  out0;
        int  v;
        bit  acc;
        bit  got;

        // Reset state
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_count", int'(count), 0);
        check("rst_out_data", int'(out_data), 0);
        tick();
        reset = 1'b1;
        tick();

        // Latency and back-to-back pair
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h64;
        tick();
        in_data   = 8'hC8;
        tick();
        in_valid  = 1'b0;
        check("lat_count_peak", int'(count), 2);
        check("lat_not_yet_valid", int'(out_valid), 0);
        tick();
        check("lat_valid_after_3", int'(out_valid), 1);
        check("lat_first_data", int'(out_data), 'h64);
        check("lat_count_hold", int'(count), 2);
        tick();
        check("lat_second_data", int'(out_data), 'hC8);
        check("lat_count_one", int'(count), 1);
        tick();
        check("lat_empty_valid", int'(out_valid), 0);
        check("lat_empty_count", int'(count), 0);

        // Fill under backpressure: only six of eight are taken
        out_ready = 1'b0;
        acc0 = n_acc;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        check("full_accepts", n_acc - acc0, 6);
        check("full_count", int'(count), 6);
        check("full_in_ready", int'(in_ready), 0);
        check("full_last_accepted", int'(exp_q[exp_q.size()-1]), 6);
        out_ready = 1'b1;
        out0 = n_out;
        for (int i = 0; i < 6; i++) begin
            check("drain_back_to_back", int'(out_valid), 1);
            tick();
        end
        check("drain_six_out", n_out - out0, 6);
        check("drain_count", int'(count), 0);
        check("drain_valid_low", int'(out_valid), 0);

        // Full stream with toggling backpressure
        out0 = n_out;
        v = 0;
        for (int i = 0; i < 2000 && v <= 255; i++) begin
            in_valid  = 1'b1;
            in_data   = 8'(v);
            out_ready = ~out_ready;
            acc = in_ready;
            tick();
            if (acc) v++;
        end
        in_valid = 1'b0;
        check("stream_all_sent", v, 256);
        drain();
        check("stream_all_out", n_out - out0, 256);

        // Flush discards stored entries and the same-cycle push
        out_ready = 1'b0;
        push(8'h31);
        push(8'h32);
        push(8'h33);
        push(8'h34);
        check("pre_flush_count", int'(count), 4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("flush_count", int'(count), 0);
        check("flush_out_valid", int'(out_valid), 0);
        check("flush_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        push(8'h55);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (out_valid) begin
                got = 1'b1;
                check("post_flush_first", int'(out_data), 'h55);
            end else begin
                tick();
            end
        end
        check("post_flush_seen", int'(got), 1);
        drain();

        // Asynchronous reset mid-stream
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hE0 + i);
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        in_valid = 1'b0;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_count", int'(count), 0);
        check("arst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h11;
        tick();
        in_valid = 1'b0;
        tick();
        check("arst_lat_not_yet", int'(out_valid), 0);
        tick();
        check("arst_lat_valid", int'(out_valid), 1);
        check("arst_lat_data", int'(out_data), 'h11);
        drain();

        // Push and pop together while full
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h41 + i));
        check("pp_full_count", int'(count), 6);
        check("pp_full_ready", int'(in_ready), 0);
        in_valid  = 1'b1;
        in_data   = 8'h99;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pp_count_after", int'(count), 5);
        got = 1'b0;
        for (int i = 0; i < DEPTH && !got; i++) begin
            got = in_ready;
            if (!got) tick();
        end
        check("pp_ready_recovers", int'(got), 1);
        check("pp_count_stable", int'(count), 5);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
